// File: rtl/ecc_pkg.sv
// Shared ECC datapath definitions: field size, reduction polynomial and
// squarer-sequencer state encoding.
package ecc_pkg;

  localparam int FF_M = 163;

  // Low-order terms of f(x) = x^163 + x^7 + x^6 + x^3 + 1
  localparam logic [FF_M-1:0] FF_POLY_LOW = 163'hC9;

  typedef logic [FF_M-1:0] ff_elem_t;

  typedef enum logic [1:0] {
    SQS_IDLE = 2'd0,
    SQS_RUN  = 2'd1,
    SQS_DONE = 2'd2
  } sqs_state_t;

endpackage

// File: rtl/ff_squarer.sv
// Combinational GF(2^163) squarer: spreads the operand bits to even positions
// and folds the upper half back with the reduction polynomial.
module ff_squarer
  import ecc_pkg::*;
(
  input  ff_elem_t i_a,
  output ff_elem_t o_c
);

  logic [2*FF_M-2:0] w_t;

  // Fold from the top down so the terms produced by each fold get reduced later
  always_comb begin
    w_t = '0;
    for (int i = 0; i < FF_M; i++) begin
      w_t[2*i] = i_a[i];
    end
    for (int i = 2*FF_M-2; i >= FF_M; i--) begin
      if (w_t[i]) begin
        w_t[i] = 1'b0;
        w_t[i-FF_M +: FF_M] = w_t[i-FF_M +: FF_M] ^ FF_POLY_LOW;
      end
    end
  end

  assign o_c = w_t[FF_M-1:0];

endmodule

// File: rtl/ff_sqr_seq.sv
// Multi-squaring sequencer: c = a^(2^n), applying up to SPC chained squarings
// per clock, with a start/done handshake.
module ff_sqr_seq
  import ecc_pkg::*;
#(
  parameter int SPC   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  ff_elem_t         a,
  input  logic [CNT_W-1:0] n,
  output ff_elem_t         c,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] SPC_CNT = CNT_W'(SPC);

  sqs_state_t       r_state;
  sqs_state_t       w_nextState;
  ff_elem_t         r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_k;
  logic [CNT_W-1:0] w_cntNext;
  ff_elem_t         w_chain [0:SPC];
  ff_elem_t         w_sqOut;
  logic             w_accept;

  assign w_chain[0] = r_acc;

  for (genvar g = 0; g < SPC; g++) begin : g_sq
    ff_squarer u_sq (
      .i_a (w_chain[g]),
      .o_c (w_chain[g+1])
    );
  end

  // The final step may need fewer than SPC squarings, so tap the chain at k
  assign w_k       = (r_cnt < SPC_CNT) ? r_cnt : SPC_CNT;
  assign w_cntNext = r_cnt - w_k;

  always_comb begin
    w_sqOut = w_chain[SPC];
    for (int i = 1; i < SPC; i++) begin
      if (w_k == CNT_W'(i)) w_sqOut = w_chain[i];
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    busy        = (r_state == SQS_RUN);
    done        = (r_state == SQS_DONE);
    case (r_state)
      SQS_IDLE, SQS_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = (n != '0) ? SQS_RUN : SQS_DONE;
        end else begin
          w_nextState = SQS_IDLE;
        end
      end
      SQS_RUN: begin
        if (w_cntNext == '0) w_nextState = SQS_DONE;
      end
      default: w_nextState = SQS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SQS_IDLE;
    else     r_state <= w_nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= a;
      r_cnt <= n;
    end else if (r_state == SQS_RUN) begin
      r_acc <= w_sqOut;
      r_cnt <= w_cntNext;
    end
  end

  assign c = r_acc;

endmodule

// File: tb/tb_ff_sqr_seq.sv
// Randomised bench for ff_sqr_seq: two instances (1 and 4 squarings per clock)
// checked every cycle against a cycle-counting behavioural model.
module tb_ff_sqr_seq;
  import ecc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  ff_elem_t   a = '0;
  logic [7:0] n = '0;

  ff_elem_t cOut [2];
  logic     busyOut [2];
  logic     doneOut [2];

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  int       spc [2] = '{1, 4};
  int       cyc = 0;
  int       mStart [2];
  int       mDone [2];
  ff_elem_t mC [2];

  always #5 clk = ~clk;

  ff_sqr_seq #(.SPC(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .n(n),
    .c(cOut[0]), .busy(busyOut[0]), .done(doneOut[0])
  );

  ff_sqr_seq #(.SPC(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .n(n),
    .c(cOut[1]), .busy(busyOut[1]), .done(doneOut[1])
  );

  // Reference field arithmetic: shift-and-add multiply, square = x*x
  function automatic ff_elem_t gfMul(ff_elem_t x, ff_elem_t y);
    ff_elem_t r = '0;
    logic carry;
    for (int i = FF_M-1; i >= 0; i--) begin
      carry = r[FF_M-1];
      r = r << 1;
      if (carry) r = r ^ 163'hC9;
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic ff_elem_t pow2n(ff_elem_t x, int cnt);
    ff_elem_t r = x;
    for (int i = 0; i < cnt; i++) r = gfMul(r, r);
    return r;
  endfunction

  function automatic int latency(int cnt, int s);
    return (cnt == 0) ? 1 : (cnt + s - 1) / s + 1;
  endfunction

  function automatic ff_elem_t randElem();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[FF_M-1:0];
  endfunction

  task automatic checkOutput(input string name, input ff_elem_t act, input ff_elem_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: each transaction occupies an absolute window of cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mStart[d] = -10;
        mDone[d]  = -10;
        mC[d]     = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!(cyc >= mStart[d] && cyc < mDone[d]) && start) begin
          mStart[d] = cyc + 1;
          mDone[d]  = cyc + latency(int'(n), spc[d]);
          mC[d]     = pow2n(a, int'(n));
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        bit expBusy;
        expBusy = (cyc >= mStart[d]) && (cyc < mDone[d]);
        checkInt($sformatf("busy%0d@%0d", d, cyc), int'(busyOut[d]), int'(expBusy));
        checkInt($sformatf("done%0d@%0d", d, cyc), int'(doneOut[d]), int'(cyc == mDone[d]));
        if (!expBusy) checkOutput($sformatf("c%0d@%0d", d, cyc), cOut[d], mC[d]);
      end
    end
  end

  task automatic applyStimulus(input ff_elem_t aVal, input int nVal);
    @(posedge clk);
    #2;
    a = aVal;
    n = 8'(nVal);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Returns at the negedge where the later of the two done pulses is seen
  task automatic waitBoth(input int maxCyc, output int lat0, output int lat1, output int busy0);
    lat0 = -1;
    lat1 = -1;
    busy0 = 0;
    for (int k = 1; k <= maxCyc; k++) begin
      @(negedge clk);
      if (busyOut[0] && lat0 < 0) busy0++;
      if (doneOut[0] && lat0 < 0) lat0 = k;
      if (doneOut[1] && lat1 < 0) lat1 = k;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    if (lat0 < 0 || lat1 < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: lat0=%0d lat1=%0d required both done within %0d", lat0, lat1, maxCyc);
    end
  endtask

  initial begin
    ff_elem_t one, x, y, a0;
    int l0, l1, b0, dn;
    one = 1;

    checkOutput("pin_sq_b81", pow2n(one << 81, 1), one << 162);
    checkOutput("pin_sq_b82", pow2n(one << 82, 1), 163'h192);
    checkOutput("pin_one", pow2n(one, 5), one);
    x = randElem();
    checkOutput("pin_period", pow2n(x, 163), x);

    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_c", cOut[0], '0);
    checkInt("rst_busy", int'(busyOut[0]), 0);
    checkInt("rst_done", int'(doneOut[1]), 0);
    checking = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;

    applyStimulus(one, 5);
    waitBoth(50, l0, l1, b0);
    checkInt("t1_lat_spc1", l0, 6);
    checkInt("t1_lat_spc4", l1, 3);
    checkInt("t1_busy_cycles", b0, 5);
    checkOutput("t1_c", cOut[0], one);

    applyStimulus(one << 81, 1);
    waitBoth(50, l0, l1, b0);
    checkOutput("t2a_c", cOut[0], one << 162);
    applyStimulus(one << 82, 1);
    waitBoth(50, l0, l1, b0);
    checkOutput("t2b_c_spc1", cOut[0], 163'h192);
    checkOutput("t2b_c_spc4", cOut[1], 163'h192);

    x = randElem();
    applyStimulus(x, 163);
    waitBoth(300, l0, l1, b0);
    checkInt("t3_lat_spc1", l0, 164);
    checkInt("t3_lat_spc4", l1, 42);
    checkOutput("t3_c_spc1", cOut[0], x);
    checkOutput("t3_c_spc4", cOut[1], x);

    applyStimulus(163'h5A5, 0);
    waitBoth(10, l0, l1, b0);
    checkInt("t4_lat", l0, 1);
    checkOutput("t4_c", cOut[0], 163'h5A5);
    y = randElem();
    a = y;
    n = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    waitBoth(20, l0, l1, b0);
    checkInt("t4_b2b_lat_spc1", l0, 4);
    checkInt("t4_b2b_lat_spc4", l1, 2);
    checkOutput("t4_b2b_c", cOut[0], pow2n(y, 3));

    a0 = randElem();
    applyStimulus(a0, 10);
    repeat (2) @(posedge clk);
    #2;
    a = randElem();
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    waitBoth(50, l0, l1, b0);
    checkOutput("t5_c_spc1", cOut[0], pow2n(a0, 10));
    checkOutput("t5_c_spc4", cOut[1], pow2n(a0, 10));

    applyStimulus(randElem(), 20);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkInt("t6_busy", int'(busyOut[0]), 0);
    checkInt("t6_done", int'(doneOut[0]), 0);
    checkOutput("t6_c", cOut[0], '0);
    @(posedge clk);
    #2 rst = 1'b0;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (doneOut[0] || doneOut[1]) dn++;
    end
    checkInt("t6_no_done", dn, 0);
    y = randElem();
    applyStimulus(y, 7);
    waitBoth(50, l0, l1, b0);
    checkInt("t6_lat_spc1", l0, 8);
    checkInt("t6_lat_spc4", l1, 3);
    checkOutput("t6_c_after", cOut[1], pow2n(y, 7));

    // Random traffic, including starts while busy and back-to-back starts
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      start = ($urandom_range(0, 3) == 0);
      a = randElem();
      n = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
    end
    @(posedge clk);
    #2 start = 1'b0;
    dn = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busyOut[0] && !busyOut[1]) break;
      dn++;
    end
    checkInt("rand_drain_timeout", int'(dn >= 300), 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
